// File: rtl/reg_intf_router.sv
// reg_intf_router: routes one upstream register request to one of NUM_TGT
// register slaves, tracks the outstanding read, times it out, counts errors.
module reg_intf_router #(
    parameter int unsigned NUM_TGT     = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_W-1:0]         reg_addr_i,
    input  logic [DATA_W-1:0]         reg_wr_data_i,
    input  logic                      reg_wr_en_i,
    input  logic                      reg_rd_en_i,
    input  logic [SEL_W-1:0]          tgt_sel_i,
    output logic [DATA_W-1:0]         reg_rd_data_o,
    output logic                      reg_rd_done_o,
    output logic                      reg_rd_err_o,
    output logic                      busy_o,
    output logic [7:0]                err_cnt_o,
    output logic [ADDR_W-1:0]         tgt_addr_o,
    output logic [DATA_W-1:0]         tgt_wr_data_o,
    output logic [NUM_TGT-1:0]        tgt_wr_en_o,
    output logic [NUM_TGT-1:0]        tgt_rd_en_o,
    input  logic [NUM_TGT*DATA_W-1:0] tgt_rd_data_i,
    input  logic [NUM_TGT-1:0]        tgt_rd_done_i
);

    localparam logic [DATA_W-1:0] ERR_VAL = DATA_W'(ERR_DATA);
    localparam logic [15:0]       TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [15:0]        cnt_q;
    logic               sel_ok;
    logic [NUM_TGT-1:0] sel_oh;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_done;
    logic               timeout;
    logic               err_evt;

    // Decode the incoming index into a validity flag and a one-hot strobe mask.
    always_comb begin
        sel_ok = 32'(tgt_sel_i) < NUM_TGT;
        sel_oh = NUM_TGT'(1) << tgt_sel_i;
    end

    // Pick the done strobe and read data of the target holding the open read.
    always_comb begin
        sel_data = '0;
        sel_done = 1'b0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_data = tgt_rd_data_i[k*DATA_W +: DATA_W];
                sel_done = tgt_rd_done_i[k];
            end
        end
    end

    // Collapse every error source of this cycle into a single count event.
    always_comb begin
        timeout = (cnt_q == TO_LAST);
        err_evt = 1'b0;
        case (state_q)
            IDLE: begin
                err_evt = reg_wr_en_i & (reg_rd_en_i | ~sel_ok);
            end
            RD_WAIT: begin
                err_evt = reg_wr_en_i | reg_rd_en_i | (timeout & ~sel_done);
            end
            RESP: begin
                err_evt = reg_wr_en_i | reg_rd_en_i | ~reg_rd_done_o;
            end
            default: begin
                err_evt = 1'b0;
            end
        endcase
    end

    // Request routing FSM with registered target strobes and response.
    // A timeout preloads the error response on entry to RESP; a bad-select
    // read enters RESP with nothing shown yet, so RESP raises it one cycle on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            reg_rd_data_o <= '0;
            reg_rd_done_o <= 1'b0;
            reg_rd_err_o  <= 1'b0;
            busy_o        <= 1'b0;
            err_cnt_o     <= '0;
            tgt_addr_o    <= '0;
            tgt_wr_data_o <= '0;
            tgt_wr_en_o   <= '0;
            tgt_rd_en_o   <= '0;
        end else begin
            tgt_wr_en_o   <= '0;
            tgt_rd_en_o   <= '0;
            reg_rd_done_o <= 1'b0;
            reg_rd_err_o  <= 1'b0;
            if (err_evt && err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (reg_rd_en_i) begin
                        sel_q  <= tgt_sel_i;
                        cnt_q  <= '0;
                        busy_o <= 1'b1;
                        if (sel_ok) begin
                            tgt_addr_o  <= reg_addr_i;
                            tgt_rd_en_o <= sel_oh;
                            state_q     <= RD_WAIT;
                        end else begin
                            state_q <= RESP;
                        end
                    end else if (reg_wr_en_i && sel_ok) begin
                        tgt_addr_o    <= reg_addr_i;
                        tgt_wr_data_o <= reg_wr_data_i;
                        tgt_wr_en_o   <= sel_oh;
                    end
                end
                RD_WAIT: begin
                    if (sel_done) begin
                        reg_rd_data_o <= sel_data;
                        reg_rd_done_o <= 1'b1;
                        busy_o        <= 1'b0;
                        state_q       <= IDLE;
                    end else if (timeout) begin
                        reg_rd_data_o <= ERR_VAL;
                        reg_rd_done_o <= 1'b1;
                        reg_rd_err_o  <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    if (reg_rd_done_o) begin
                        busy_o  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        reg_rd_data_o <= ERR_VAL;
                        reg_rd_done_o <= 1'b1;
                        reg_rd_err_o  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_intf_router.sv
// tb_reg_intf_router: directed checks of routing, read completion, timeout,
// error responses, error counting and reset abort.
module tb_reg_intf_router;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   addr;
    logic [31:0]  wdata;
    logic         wr, rd;
    logic [1:0]   sel;
    logic [127:0] t_rdata;
    logic [3:0]   t_done;
    logic [31:0]  rdata;
    logic         done, err, busy;
    logic [7:0]   ecnt, taddr;
    logic [31:0]  twdata;
    logic [3:0]   twen, tren;

    logic         wr3, rd3;
    logic [1:0]   sel3;
    logic [95:0]  t_rdata3;
    logic [2:0]   t_done3;
    logic [31:0]  rdata3;
    logic         done3, err3, busy3;
    logic [7:0]   ecnt3, taddr3;
    logic [31:0]  twdata3;
    logic [2:0]   twen3, tren3;

    int total = 0;
    int bad = 0;

    reg_intf_router #(
        .NUM_TGT(4), .ADDR_W(8), .DATA_W(32), .SEL_W(2),
        .TIMEOUT_CYC(16), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_addr_i(addr), .reg_wr_data_i(wdata),
        .reg_wr_en_i(wr), .reg_rd_en_i(rd), .tgt_sel_i(sel),
        .reg_rd_data_o(rdata), .reg_rd_done_o(done),
        .reg_rd_err_o(err), .busy_o(busy), .err_cnt_o(ecnt),
        .tgt_addr_o(taddr), .tgt_wr_data_o(twdata),
        .tgt_wr_en_o(twen), .tgt_rd_en_o(tren),
        .tgt_rd_data_i(t_rdata), .tgt_rd_done_i(t_done)
    );

    reg_intf_router #(
        .NUM_TGT(3), .ADDR_W(8), .DATA_W(32), .SEL_W(2),
        .TIMEOUT_CYC(16), .ERR_DATA(32'hDEAD_BEEF)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_addr_i(addr), .reg_wr_data_i(wdata),
        .reg_wr_en_i(wr3), .reg_rd_en_i(rd3), .tgt_sel_i(sel3),
        .reg_rd_data_o(rdata3), .reg_rd_done_o(done3),
        .reg_rd_err_o(err3), .busy_o(busy3), .err_cnt_o(ecnt3),
        .tgt_addr_o(taddr3), .tgt_wr_data_o(twdata3),
        .tgt_wr_en_o(twen3), .tgt_rd_en_o(tren3),
        .tgt_rd_data_i(t_rdata3), .tgt_rd_done_i(t_done3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        addr = '0; wdata = '0; wr = 0; rd = 0; sel = '0;
        t_rdata = '0; t_done = '0;
        wr3 = 0; rd3 = 0; sel3 = '0; t_rdata3 = '0; t_done3 = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        total++;
        if ({rdata, done, err, busy, ecnt, taddr, twdata, twen, tren} !== '0) begin
            bad++;
            $display("FAIL reset_async: got busy=%b done=%b ecnt=%0d taddr=%h", busy, done, ecnt, taddr);
        end
        tick();
        total++;
        if ({rdata3, done3, err3, busy3, ecnt3, taddr3, twdata3, twen3, tren3} !== '0) begin
            bad++;
            $display("FAIL reset_dut3: got busy=%b done=%b ecnt=%0d", busy3, done3, ecnt3);
        end
        rst_n = 1;
    endtask

    task automatic test_write();
        reset_dut();
        wr = 1; sel = 2; addr = 8'h10; wdata = 32'hA5A5_0001;
        tick();
        wr = 0; addr = 8'h00; wdata = '0;
        total++;
        if (twen !== 4'b0100 || tren !== 4'b0000) begin
            bad++;
            $display("FAIL wr_pulse: got wen=%b ren=%b exp wen=0100 ren=0000", twen, tren);
        end
        total++;
        if (taddr !== 8'h10 || twdata !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL wr_bus: got addr=%h data=%h exp 10 a5a50001", taddr, twdata);
        end
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_noresp: got done=%b busy=%b exp 0 0", done, busy);
        end
        tick();
        total++;
        if (twen !== 4'b0000 || done !== 1'b0 || ecnt !== 8'd0) begin
            bad++;
            $display("FAIL wr_one_cycle: got wen=%b done=%b ecnt=%0d exp 0000 0 0", twen, done, ecnt);
        end
    endtask

    task automatic test_read();
        reset_dut();
        rd = 1; sel = 1; addr = 8'h20;
        tick();
        rd = 0;
        total++;
        if (tren !== 4'b0010 || taddr !== 8'h20 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rd_pulse: got ren=%b addr=%h busy=%b exp 0010 20 1", tren, taddr, busy);
        end
        tick();
        total++;
        if (tren !== 4'b0000) begin
            bad++;
            $display("FAIL rd_pulse_len: got ren=%b exp 0000", tren);
        end
        tick();
        tick();
        t_done = 4'b0010;
        t_rdata[32 +: 32] = 32'h1234_5678;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rd_early: got done=%b busy=%b exp 0 1", done, busy);
        end
        tick();
        t_done = '0;
        t_rdata = '0;
        total++;
        if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h1234_5678 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_resp: got done=%b err=%b data=%h busy=%b exp 1 0 12345678 0", done, err, rdata, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || rdata !== 32'h1234_5678 || ecnt !== 8'd0) begin
            bad++;
            $display("FAIL rd_hold: got done=%b data=%h ecnt=%0d exp 0 12345678 0", done, rdata, ecnt);
        end
    endtask

    task automatic test_timeout();
        logic early;
        reset_dut();
        early = 0;
        rd = 1; sel = 3; addr = 8'h30;
        tick();
        rd = 0;
        total++;
        if (tren !== 4'b1000) begin
            bad++;
            $display("FAIL to_pulse: got ren=%b exp 1000", tren);
        end
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b1) early = 1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL to_early: got early response or idle before C1+16");
        end
        tick();
        total++;
        if (done !== 1'b1 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF || busy !== 1'b1) begin
            bad++;
            $display("FAIL to_resp: got done=%b err=%b data=%h busy=%b exp 1 1 deadbeef 1", done, err, rdata, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || ecnt !== 8'd1) begin
            bad++;
            $display("FAIL to_after: got done=%b busy=%b ecnt=%0d exp 0 0 1", done, busy, ecnt);
        end
    endtask

    task automatic test_ignore();
        reset_dut();
        rd = 1; sel = 0; addr = 8'h40;
        tick();
        rd = 0;
        tick();
        t_done = 4'b0010;
        t_rdata[32 +: 32] = 32'h0000_0BAD;
        rd = 1; sel = 2;
        tick();
        t_done = '0;
        rd = 0;
        total++;
        if (tren !== 4'b0000 || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ign_drop: got ren=%b done=%b busy=%b exp 0000 0 1", tren, done, busy);
        end
        total++;
        if (ecnt !== 8'd1) begin
            bad++;
            $display("FAIL ign_ecnt: got %0d exp 1", ecnt);
        end
        t_done = 4'b0001;
        t_rdata[0 +: 32] = 32'hCAFE_0000;
        tick();
        t_done = '0;
        total++;
        if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hCAFE_0000 || ecnt !== 8'd1) begin
            bad++;
            $display("FAIL ign_resp: got done=%b err=%b data=%h ecnt=%0d exp 1 0 cafe0000 1", done, err, rdata, ecnt);
        end
    endtask

    task automatic test_simul();
        reset_dut();
        wr = 1; rd = 1; sel = 2; addr = 8'h50; wdata = 32'h0000_0055;
        tick();
        wr = 0; rd = 0;
        t_done = 4'b0100;
        t_rdata[64 +: 32] = 32'h0000_2222;
        total++;
        if (tren !== 4'b0100 || twen !== 4'b0000 || ecnt !== 8'd1) begin
            bad++;
            $display("FAIL sim_route: got ren=%b wen=%b ecnt=%0d exp 0100 0000 1", tren, twen, ecnt);
        end
        tick();
        t_done = '0;
        total++;
        if (done !== 1'b1 || rdata !== 32'h0000_2222 || twdata !== 32'h0) begin
            bad++;
            $display("FAIL sim_resp: got done=%b data=%h wdata=%h exp 1 00002222 0", done, rdata, twdata);
        end
    endtask

    task automatic test_bad_sel();
        reset_dut();
        rd3 = 1; sel3 = 3;
        tick();
        rd3 = 0;
        total++;
        if (tren3 !== 3'b000 || done3 !== 1'b0 || busy3 !== 1'b1) begin
            bad++;
            $display("FAIL bs_c1: got ren=%b done=%b busy=%b exp 000 0 1", tren3, done3, busy3);
        end
        tick();
        total++;
        if (done3 !== 1'b1 || err3 !== 1'b1 || rdata3 !== 32'hDEAD_BEEF || tren3 !== 3'b000) begin
            bad++;
            $display("FAIL bs_resp: got done=%b err=%b data=%h ren=%b exp 1 1 deadbeef 000", done3, err3, rdata3, tren3);
        end
        tick();
        total++;
        if (done3 !== 1'b0 || busy3 !== 1'b0 || ecnt3 !== 8'd1) begin
            bad++;
            $display("FAIL bs_after: got done=%b busy=%b ecnt=%0d exp 0 0 1", done3, busy3, ecnt3);
        end
        wr3 = 1; sel3 = 3; wdata = 32'h0000_0077;
        tick();
        wr3 = 0;
        total++;
        if (twen3 !== 3'b000 || ecnt3 !== 8'd2) begin
            bad++;
            $display("FAIL bs_write: got wen=%b ecnt=%0d exp 000 2", twen3, ecnt3);
        end
    endtask

    task automatic test_saturate();
        logic any_wen;
        reset_dut();
        any_wen = 0;
        for (int i = 1; i <= 260; i++) begin
            wr3 = 1; sel3 = 3;
            tick();
            if (twen3 !== 3'b000) any_wen = 1;
            if (i == 100) begin
                total++;
                if (ecnt3 !== 8'd100) begin
                    bad++;
                    $display("FAIL sat_mid: got %0d exp 100", ecnt3);
                end
            end
        end
        wr3 = 0;
        tick();
        total++;
        if (ecnt3 !== 8'd255 || any_wen !== 1'b0) begin
            bad++;
            $display("FAIL sat_top: got ecnt=%0d wen_seen=%b exp 255 0", ecnt3, any_wen);
        end
    endtask

    task automatic test_reset_mid();
        logic stale;
        reset_dut();
        stale = 0;
        rd = 1; sel = 0; addr = 8'h44;
        tick();
        rd = 0;
        tick();
        rst_n = 0;
        t_done = 4'b0001;
        t_rdata[0 +: 32] = 32'h9999_9999;
        #1;
        total++;
        if ({rdata, done, err, busy, ecnt, taddr, twdata, twen, tren} !== '0) begin
            bad++;
            $display("FAIL rm_zero: got busy=%b taddr=%h done=%b", busy, taddr, done);
        end
        tick();
        rst_n = 1;
        t_done = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) stale = 1;
        end
        total++;
        if (stale !== 1'b0) begin
            bad++;
            $display("FAIL rm_stale: got response or busy after reset release");
        end
        rd = 1; sel = 0; addr = 8'h45;
        tick();
        rd = 0;
        t_done = 4'b0001;
        t_rdata[0 +: 32] = 32'h0000_0077;
        total++;
        if (tren !== 4'b0001 || taddr !== 8'h45) begin
            bad++;
            $display("FAIL rm_rd_pulse: got ren=%b addr=%h exp 0001 45", tren, taddr);
        end
        tick();
        t_done = '0;
        total++;
        if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h0000_0077) begin
            bad++;
            $display("FAIL rm_rd_resp: got done=%b err=%b data=%h exp 1 0 00000077", done, err, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ignore();
        test_simul();
        test_bad_sel();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
